// File: rtl/display_pkg.sv
// Shared types and constants for the five-digit BCD display path.
// Holds the converter state enum and the shift-add-3 step used on the accumulator.
package display_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 4;
  localparam int ACC_W      = NUM_DIGITS * BCD_W;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
  function automatic logic [ACC_W-1:0] bcd_step(input logic [ACC_W-1:0] acc, input logic b);
    logic [ACC_W-1:0] adj;
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[i*BCD_W +: BCD_W] >= 4'd5) adj[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W] + 4'd3;
    end
    return (adj << 1) | ACC_W'(b);
  endfunction

endpackage

// File: rtl/digit_scanner.sv
// Multiplexed digit scan: advances one digit every REFRESH_DIV cycles, free-running, no backpressure.
// Select, BCD and blank outputs are registered together from the next index.
module digit_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_DIGITS-1:0][BCD_W-1:0]  digits,
  output logic [NUM_DIGITS-1:0]             digit_sel,
  output logic [BCD_W-1:0]                  digit_bcd,
  output logic                              digit_blank
);

  localparam int              CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]    LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             blank_nxt;

  always_comb begin
    idx_nxt = idx;
    if (cnt == LAST) idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    blank_nxt = (idx_nxt != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) >= idx_nxt && digits[i] != '0) blank_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      idx         <= '0;
      digit_sel   <= NUM_DIGITS'(1);
      digit_bcd   <= '0;
      digit_blank <= 1'b0;
    end else begin
      cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
      idx         <= idx_nxt;
      digit_sel   <= NUM_DIGITS'(1) << idx_nxt;
      digit_bcd   <= digits[idx_nxt];
      digit_blank <= blank_nxt;
    end
  end

endmodule

// File: rtl/bcd_display_controller.sv
// Binary-to-BCD converter feeding a scanned 5-digit display; conv_done N+1 cycles after handshake.
// Single-entry valid/ready: value_ready drops for the whole conversion, offers meanwhile are ignored.
module bcd_display_controller
  import display_pkg::*;
#(
  parameter int N           = 10,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          value,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic                  conv_done,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [BCD_W-1:0]      digit_bcd,
  output logic                  digit_blank
);

  localparam int CNT_W = $clog2(N + 1);

  state_t                            state;
  logic [N-1:0]                      shreg;
  logic [ACC_W-1:0]                  acc;
  logic [ACC_W-1:0]                  acc_nxt;
  logic [CNT_W-1:0]                  bitcnt;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  digits;

  assign acc_nxt = bcd_step(acc, shreg[N-1]);

  // The final shift result goes straight into the display registers so they are
  // valid in the same cycle conv_done is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      acc         <= '0;
      bitcnt      <= '0;
      digits      <= '0;
      value_ready <= 1'b1;
      conv_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          conv_done <= 1'b0;
          if (value_valid) begin
            shreg       <= value;
            acc         <= '0;
            bitcnt      <= CNT_W'(N);
            value_ready <= 1'b0;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          acc    <= acc_nxt;
          shreg  <= shreg << 1;
          bitcnt <= bitcnt - 1'b1;
          if (bitcnt == CNT_W'(1)) begin
            digits    <= acc_nxt;
            conv_done <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          conv_done   <= 1'b0;
          value_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          conv_done   <= 1'b0;
          value_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  digit_scanner #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk         (clk),
    .reset_n     (reset_n),
    .digits      (digits),
    .digit_sel   (digit_sel),
    .digit_bcd   (digit_bcd),
    .digit_blank (digit_blank)
  );

endmodule

// File: tb/tb_bcd_display_controller.sv
// Bench for bcd_display_controller: an N=10 and an N=16 instance against a decimal/scan reference model.
module tb_bcd_display_controller;

  localparam int N10  = 10;
  localparam int RD10 = 4;
  localparam int N16  = 16;
  localparam int RD16 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [9:0]  value10 = '0;
  logic        vv10 = 1'b0;
  logic        rdy10, done10, blk10;
  logic [4:0]  sel10;
  logic [3:0]  bcd10;

  logic [15:0] value16 = '0;
  logic        vv16 = 1'b0;
  logic        rdy16, done16, blk16;
  logic [4:0]  sel16;
  logic [3:0]  bcd16;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int disp10 = 0;
  int disp16 = 0;

  always #5 clk = ~clk;

  // Posedges since reset release; the scanned index is floor(edges/RD) mod 5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  bcd_display_controller #(.N(N10), .REFRESH_DIV(RD10)) dut10 (
    .clk(clk), .reset_n(rst_n), .value(value10), .value_valid(vv10), .value_ready(rdy10),
    .conv_done(done10), .digit_sel(sel10), .digit_bcd(bcd10), .digit_blank(blk10)
  );

  bcd_display_controller #(.N(N16), .REFRESH_DIV(RD16)) dut16 (
    .clk(clk), .reset_n(rst_n), .value(value16), .value_valid(vv16), .value_ready(rdy16),
    .conv_done(done16), .digit_sel(sel16), .digit_bcd(bcd16), .digit_blank(blk16)
  );

  function automatic int p10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic int dig(input int v, input int i);
    return (v / p10(i)) % 10;
  endfunction

  function automatic logic blank_of(input int v, input int i);
    return (i > 0) && (v < p10(i));
  endfunction

  // Checks the N=10 scan outputs against the model for ncyc cycles.
  task automatic scan10(input int ncyc);
    int idx;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      idx = (edges / RD10) % 5;
      checks++;
      if (sel10 !== 5'(1 << idx)) begin
        errors++; $display("FAIL scan10_sel disp=%0d: got %b expected %b", disp10, sel10, 5'(1 << idx));
      end
      checks++;
      if (bcd10 !== 4'(dig(disp10, idx))) begin
        errors++; $display("FAIL scan10_bcd disp=%0d idx=%0d: got %0d expected %0d", disp10, idx, bcd10, dig(disp10, idx));
      end
      checks++;
      if (blk10 !== blank_of(disp10, idx)) begin
        errors++; $display("FAIL scan10_blank disp=%0d idx=%0d: got %b expected %b", disp10, idx, blk10, blank_of(disp10, idx));
      end
    end
  endtask

  // Caller is at a negedge: offers v now (cycle 0) and follows the conversion to cycle N+2.
  task automatic do_conv10(input int v);
    int idx;
    value10 = 10'(v);
    vv10 = 1'b1;
    checks++;
    if (rdy10 !== 1'b1) begin
      errors++; $display("FAIL conv10_ready_c0 v=%0d: got %b expected 1", v, rdy10);
    end
    for (int c = 1; c <= N10 + 1; c++) begin
      @(negedge clk);
      if (c == 1) vv10 = 1'b0;
      idx = (edges / RD10) % 5;
      checks++;
      if (rdy10 !== 1'b0) begin
        errors++; $display("FAIL conv10_ready_busy v=%0d c=%0d: got %b expected 0", v, c, rdy10);
      end
      checks++;
      if (done10 !== (c == N10 + 1)) begin
        errors++; $display("FAIL conv10_done v=%0d c=%0d: got %b expected %b", v, c, done10, (c == N10 + 1));
      end
      checks++;
      if (sel10 !== 5'(1 << idx) || bcd10 !== 4'(dig(disp10, idx)) || blk10 !== blank_of(disp10, idx)) begin
        errors++;
        $display("FAIL conv10_scan_busy c=%0d: got sel=%b bcd=%0d blank=%b expected sel=%b bcd=%0d blank=%b",
                 c, sel10, bcd10, blk10, 5'(1 << idx), dig(disp10, idx), blank_of(disp10, idx));
      end
    end
    disp10 = v;
    @(negedge clk);
    checks++;
    if (rdy10 !== 1'b1 || done10 !== 1'b0) begin
      errors++; $display("FAIL conv10_after v=%0d: got ready=%b done=%b expected ready=1 done=0", v, rdy10, done10);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sel10 !== 5'b00001 || bcd10 !== 4'd0 || blk10 !== 1'b0 || done10 !== 1'b0) begin
      errors++; $display("FAIL reset10_outputs: got sel=%b bcd=%0d blank=%b done=%b expected 00001 0 0 0", sel10, bcd10, blk10, done10);
    end
    checks++;
    if (sel16 !== 5'b00001 || bcd16 !== 4'd0 || blk16 !== 1'b0 || done16 !== 1'b0) begin
      errors++; $display("FAIL reset16_outputs: got sel=%b bcd=%0d blank=%b done=%b expected 00001 0 0 0", sel16, bcd16, blk16, done16);
    end
    rst_n = 1'b1;
    disp10 = 0;
    disp16 = 0;
    checks++;
    if (rdy10 !== 1'b1 || rdy16 !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", rdy10, rdy16);
    end
    scan10(3);
  endtask

  task automatic test_latency_1023();
    @(negedge clk);
    do_conv10(1023);
    scan10(5 * RD10 + 1);
  endtask

  task automatic test_zero();
    @(negedge clk);
    do_conv10(0);
    scan10(5 * RD10 + 1);
  endtask

  task automatic test_hold_valid();
    int idx;
    @(negedge clk);
    value10 = 10'd1023;
    vv10 = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) value10 = 10'd7;
      if (c == 13) vv10 = 1'b0;
      if (c == 12) disp10 = 1023;
      idx = (edges / RD10) % 5;
      checks++;
      if (rdy10 !== (c == 12 || c == 24)) begin
        errors++; $display("FAIL hold_ready c=%0d: got %b expected %b", c, rdy10, (c == 12 || c == 24));
      end
      checks++;
      if (done10 !== (c == 11 || c == 23)) begin
        errors++; $display("FAIL hold_done c=%0d: got %b expected %b", c, done10, (c == 11 || c == 23));
      end
      if (c >= 12 && c <= 23) begin
        checks++;
        if (bcd10 !== 4'(dig(1023, idx))) begin
          errors++; $display("FAIL hold_first_result c=%0d idx=%0d: got %0d expected %0d", c, idx, bcd10, dig(1023, idx));
        end
      end
    end
    disp10 = 7;
    scan10(5 * RD10 + 1);
  endtask

  task automatic test_random();
    repeat (6) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      do_conv10(int'($urandom_range(0, 1023)));
      scan10(6);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    value10 = 10'(int'($urandom_range(1, 1023)));
    vv10 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) vv10 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel10 !== 5'b00001 || bcd10 !== 4'd0 || blk10 !== 1'b0 || done10 !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got sel=%b bcd=%0d blank=%b done=%b expected 00001 0 0 0", sel10, bcd10, blk10, done10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    disp10 = 0;
    disp16 = 0;
    do_conv10(int'($urandom_range(1, 1023)));
    scan10(5 * RD10 + 1);
  endtask

  task automatic test_n16();
    int vals [2];
    int idx;
    vals[0] = 65535;
    vals[1] = int'($urandom_range(0, 65535));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      value16 = 16'(vals[k]);
      vv16 = 1'b1;
      checks++;
      if (rdy16 !== 1'b1) begin
        errors++; $display("FAIL n16_ready_c0: got %b expected 1", rdy16);
      end
      for (int c = 1; c <= N16 + 2; c++) begin
        @(negedge clk);
        if (c == 1) vv16 = 1'b0;
        checks++;
        if (rdy16 !== (c == N16 + 2) || done16 !== (c == N16 + 1)) begin
          errors++;
          $display("FAIL n16_handshake v=%0d c=%0d: got ready=%b done=%b expected ready=%b done=%b",
                   vals[k], c, rdy16, done16, (c == N16 + 2), (c == N16 + 1));
        end
      end
      disp16 = vals[k];
      for (int c = 0; c < 5 * RD16 + 1; c++) begin
        @(negedge clk);
        idx = (edges / RD16) % 5;
        checks++;
        if (sel16 !== 5'(1 << idx) || bcd16 !== 4'(dig(disp16, idx)) || blk16 !== blank_of(disp16, idx)) begin
          errors++;
          $display("FAIL n16_scan v=%0d idx=%0d: got sel=%b bcd=%0d blank=%b expected sel=%b bcd=%0d blank=%b",
                   disp16, idx, sel16, bcd16, blk16, 5'(1 << idx), dig(disp16, idx), blank_of(disp16, idx));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency_1023();
    test_zero();
    test_hold_valid();
    test_random();
    test_reset_mid();
    test_n16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_controller.md
BCD_DISPLAY_CONTROLLER -- requirements
Module: bcd_display_controller

Interface
REQ-001 Parameter N, default 10: width of the binary input value; legal range 1..16.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per digit during display scanning; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 value  input  N  unsigned binary value to display.
REQ-006 value_valid  input  1  requester offers value this cycle.
REQ-007 value_ready  output  1  controller can accept a value this cycle.
REQ-008 conv_done  output  1  one-cycle pulse when new digits reach the display registers.
REQ-009 digit_sel  output  5  one-hot active-high digit enable; bit 0 = ones, bit 4 = ten-thousands.
REQ-010 digit_bcd  output  4  BCD value of the currently selected digit.
REQ-011 digit_blank  output  1  selected digit is a leading zero and must not be lit.

Function
REQ-012 FSM states: IDLE, CONVERT, LOAD.
REQ-013 IDLE: value_ready=1; on value_valid&&value_ready, capture value into the shift register, clear the 20-bit BCD accumulator, load the bit counter with N, go to CONVERT.
REQ-014 CONVERT: value_ready=0; each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,shift} left by one; decrement the bit counter; after exactly N shift cycles go to LOAD.
REQ-015 LOAD: copy the accumulator into five display digit registers, assert conv_done for this cycle only, return to IDLE.
REQ-016 Latency: handshake in cycle 0; conv_done and the new digits are visible in cycle N+1; value_ready is high again in cycle N+2.
REQ-017 value_valid while value_ready=0 is ignored; no queuing, no error.
REQ-018 Display registers hold the last completed conversion; scanning never stalls during CONVERT.
REQ-019 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap, the digit index advances 0->1->2->3->4->0.
REQ-020 digit_sel = one-hot(index); digit_bcd = display digit[index]; both are registered and change together.
REQ-021 digit_blank=1 iff index>0 and display digits index..4 are all zero; the ones digit is never blanked.
REQ-022 Arithmetic: the accumulator is 20 bits regardless of N; 2^16-1 = 65535 fits, so no overflow is possible in the legal range.

Reset
REQ-023 On reset_n low, immediately: FSM=IDLE, value_ready=1 after release, conv_done=0, display digits=0, refresh counter=0, index=0, digit_sel=5'b00001, digit_bcd=0, digit_blank=0.
REQ-024 Reset during CONVERT aborts the conversion; the partial result is never loaded and no conv_done is issued.

Structure
REQ-025 Package display_pkg holds the state enum, NUM_DIGITS=5, and BCD_W=4.
REQ-026 Sub-module digit_scanner (refresh counter, index, one-hot select, blanking) is instantiated once; the conversion FSM stays in the top module.

Verification
REQ-027 N=10, value=1023 offered in cycle 0 -> value_ready low in cycles 1..11; conv_done pulse in cycle 11; digits {4..0} = 0,1,0,2,3.
REQ-028 value=0 -> digit_bcd=0 at every index; digit_blank=1 for indices 1..4 and 0 for index 0.
REQ-029 value_valid held high with value=7 during a conversion of 1023 -> result is still 01023; 7 is accepted only once value_ready=1, 11 cycles later.
REQ-030 REFRESH_DIV=4 -> digit_sel steps 00001, 00010, 00100, 01000, 10000, 00001, changing every 4 cycles, including during CONVERT.
REQ-031 reset_n pulsed low at cycle 5 of a conversion -> no conv_done; digits remain 0; a new value is accepted in the first cycle after release.
REQ-032 N=16, value=65535 -> conv_done in cycle 17; digits 6,5,5,3,5; no blanking.
